// File: rtl/lock_controller.sv
// Canal lock sequencer: levels the pound to the entry side, passes a gondola in, moves the water, passes it out.
// All outputs are registered; gate pulses and valve drives reflect inputs sampled at the previous clock edge.
module lock_controller #(
   parameter int LEVEL_MAX   = 7,
   parameter int STEP_CYCLES = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             reqWest,
   input  logic                             reqEast,
   input  logic                             gondolaPassed,
   input  logic                             westClosed,
   input  logic                             eastClosed,
   output logic                             openWest,
   output logic                             openEast,
   output logic                             fillValve,
   output logic                             drainValve,
   output logic [$clog2(LEVEL_MAX+1)-1:0]   level,
   output logic                             busy
);
   localparam int LW = $clog2(LEVEL_MAX + 1);
   localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [LW-1:0] L_MAX  = LW'(LEVEL_MAX);
   localparam logic [SW-1:0] S_LAST = SW'(STEP_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, PREP, OPEN_IN, WAIT_IN, MOVE, OPEN_OUT, WAIT_OUT} state_t;

   state_t          r_state, w_state_n;
   logic            r_dir, w_dir_n;
   logic [LW-1:0]   r_level, w_level_n;
   logic [SW-1:0]   r_step, w_step_n;
   logic            r_fill, r_drain, r_open_w, r_open_e;
   logic            w_fill_n, w_drain_n, w_open_w_n, w_open_e_n;
   logic            w_gates_shut;
   logic [LW-1:0]   w_entry, w_exit, w_target;

   always_comb begin
      w_gates_shut = westClosed & eastClosed;
      w_entry      = r_dir ? L_MAX : '0;
      w_exit       = r_dir ? '0 : L_MAX;
      w_state_n    = r_state;
      w_dir_n      = r_dir;
      w_level_n    = r_level;
      w_step_n     = r_step;
      w_open_w_n   = 1'b0;
      w_open_e_n   = 1'b0;
      w_fill_n     = 1'b0;
      w_drain_n    = 1'b0;
      w_target     = '0;

      // A valve that ran during this cycle advances the step counter
      if (r_fill | r_drain) begin
         if (r_step == S_LAST) begin
            w_step_n = '0;
            if (r_fill && r_level != L_MAX)
               w_level_n = r_level + 1'b1;
            else if (r_drain && r_level != '0)
               w_level_n = r_level - 1'b1;
         end else begin
            w_step_n = r_step + 1'b1;
         end
      end

      case (r_state)
         IDLE: begin
            if (reqWest | reqEast) begin
               w_dir_n   = (reqWest & reqEast) ? (r_level == L_MAX) : reqEast;
               w_state_n = PREP;
               w_step_n  = '0;
            end
         end
         PREP: begin
            if (w_level_n == w_entry)
               w_state_n = OPEN_IN;
         end
         OPEN_IN: begin
            if (w_gates_shut) begin
               w_state_n  = WAIT_IN;
               w_open_w_n = ~r_dir;
               w_open_e_n = r_dir;
            end
         end
         WAIT_IN: begin
            if (gondolaPassed) begin
               w_state_n = MOVE;
               w_step_n  = '0;
            end
         end
         MOVE: begin
            if (w_level_n == w_exit)
               w_state_n = OPEN_OUT;
         end
         OPEN_OUT: begin
            if (w_gates_shut) begin
               w_state_n  = WAIT_OUT;
               w_open_w_n = r_dir;
               w_open_e_n = ~r_dir;
            end
         end
         WAIT_OUT: begin
            if (gondolaPassed)
               w_state_n = IDLE;
         end
         default: w_state_n = IDLE;
      endcase

      // Valves for the coming cycle only run in PREP/MOVE with both gates shut
      if (w_state_n == PREP)
         w_target = w_dir_n ? L_MAX : '0;
      else
         w_target = w_dir_n ? '0 : L_MAX;
      if ((w_state_n == PREP || w_state_n == MOVE) && w_gates_shut) begin
         w_fill_n  = (w_level_n < w_target);
         w_drain_n = (w_level_n > w_target);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_dir    <= 1'b0;
         r_level  <= '0;
         r_step   <= '0;
         r_fill   <= 1'b0;
         r_drain  <= 1'b0;
         r_open_w <= 1'b0;
         r_open_e <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_dir    <= w_dir_n;
         r_level  <= w_level_n;
         r_step   <= w_step_n;
         r_fill   <= w_fill_n;
         r_drain  <= w_drain_n;
         r_open_w <= w_open_w_n;
         r_open_e <= w_open_e_n;
      end
   end

   assign openWest   = r_open_w;
   assign openEast   = r_open_e;
   assign fillValve  = r_fill;
   assign drainValve = r_drain;
   assign level      = r_level;
   assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_lock_controller.sv
// Scoreboard bench for lock_controller: stimulus queues expected gate pulses, a monitor pops and checks them.
module tb_lock_controller;
   localparam int LEVEL_MAX   = 7;
   localparam int STEP_CYCLES = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       reqWest = 1'b0, reqEast = 1'b0, gondolaPassed = 1'b0;
   logic       westClosed = 1'b1, eastClosed = 1'b1;
   logic       openWest, openEast, fillValve, drainValve, busy;
   logic [2:0] level;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int kind;    // 1 = openWest, 2 = openEast
      int lvl;
      int fills;   // fill-valve cycles since previous pulse
      int drains;
      int span;    // first..last valve-active cycle, inclusive
   } ev_t;
   ev_t sb[$];
   ev_t e;

   always #5 clk = ~clk;

   lock_controller #(.LEVEL_MAX(LEVEL_MAX), .STEP_CYCLES(STEP_CYCLES)) dut (
      .clk(clk), .reset(reset), .reqWest(reqWest), .reqEast(reqEast),
      .gondolaPassed(gondolaPassed), .westClosed(westClosed), .eastClosed(eastClosed),
      .openWest(openWest), .openEast(openEast), .fillValve(fillValve),
      .drainValve(drainValve), .level(level), .busy(busy)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic expect_ev(input int k, input int l, input int f, input int d, input int s);
      ev_t x;
      x.kind = k; x.lvl = l; x.fills = f; x.drains = d; x.span = s;
      sb.push_back(x);
   endtask

   // Monitor: gate-closed values as the DUT samples them at the rising edge
   logic smp_shut = 1'b1;
   always @(posedge clk) smp_shut = westClosed & eastClosed;

   int   cyc = 0, n_fill = 0, n_drain = 0, first_v = -1, last_v = -1;
   logic prev_pulse = 1'b0;
   always @(negedge clk) begin
      cyc++;
      if (!reset) begin
         n_fill = 0; n_drain = 0; first_v = -1; last_v = -1; prev_pulse = 1'b0;
      end else begin
         chk("valve_excl", int'(fillValve & drainValve), 0);
         chk("open_excl", int'(openWest & openEast), 0);
         chk("open_vs_valve", int'((openWest | openEast) & (fillValve | drainValve)), 0);
         if (!smp_shut) chk("interlock", int'(fillValve | drainValve), 0);
         if (fillValve | drainValve) begin
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
            if (fillValve) n_fill++;
            else n_drain++;
         end
         if (openWest | openEast) begin
            chk("pulse_width", int'(prev_pulse), 0);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse: got W=%0b E=%0b at level %0d, expected none", openWest, openEast, level);
            end else begin
               e = sb.pop_front();
               chk("ev_kind", openEast ? 2 : 1, e.kind);
               chk("ev_level", int'(level), e.lvl);
               chk("ev_fill_cycles", n_fill, e.fills);
               chk("ev_drain_cycles", n_drain, e.drains);
               chk("ev_valve_span", (first_v < 0) ? 0 : last_v - first_v + 1, e.span);
            end
            n_fill = 0; n_drain = 0; first_v = -1; last_v = -1;
         end
         prev_pulse = openWest | openEast;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pass_gondola();
      @(posedge clk); #1 gondolaPassed = 1'b1;
      @(posedge clk); #1 gondolaPassed = 1'b0;
   endtask

   // which: 0 openWest, 1 openEast, 2 busy high, 3 busy low
   task automatic wait_sig(input string name, input int which, input int budget, output int n);
      bit hit;
      hit = 1'b0;
      n = 0;
      while (!hit && n < budget) begin
         @(negedge clk);
         n++;
         case (which)
            0: hit = openWest;
            1: hit = openEast;
            2: hit = busy;
            3: hit = !busy;
            default: hit = 1'b1;
         endcase
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL timeout_%s: got no event in %0d cycles, expected one", name, budget);
      end
   endtask

   int n, cnt, acc, lvl_a, lvl_b;

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish by 100000ns, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      tick(3);
      chk("rst_busy", int'(busy), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_valves", int'(fillValve | drainValve), 0);
      chk("rst_opens", int'(openWest | openEast), 0);
      @(negedge clk) reset = 1'b1;
      tick(2);
      chk("idle_busy", int'(busy), 0);

      // West-to-east trip from level 0: PREP one cycle, fill 7*4 cycles
      expect_ev(1, 0, 0, 0, 0);
      expect_ev(2, 7, 28, 0, 28);
      reqWest = 1'b1;
      wait_sig("s1_busy", 2, 10, n);
      reqWest = 1'b0;
      wait_sig("s1_openW", 0, 20, n);
      chk("s1_prep_latency", n, 2);
      pass_gondola();
      wait_sig("s1_openE", 1, 100, n);
      pass_gondola();
      wait_sig("s1_idle", 3, 10, n);
      chk("s1_final_level", int'(level), 7);

      // Both requests at LEVEL_MAX: east-to-west, no valve before openEast
      expect_ev(2, 7, 0, 0, 0);
      expect_ev(1, 0, 0, 28, 28);
      reqWest = 1'b1; reqEast = 1'b1;
      wait_sig("s2_busy", 2, 10, n);
      reqWest = 1'b0; reqEast = 1'b0;
      wait_sig("s2_openE", 1, 20, n);
      chk("s2_prep_latency", n, 2);
      pass_gondola();
      wait_sig("s2_openW", 0, 100, n);
      pass_gondola();
      wait_sig("s2_idle", 3, 10, n);
      chk("s2_final_level", int'(level), 0);

      // West gate not closed in OPEN_IN; east gate opens for 5 cycles during MOVE
      expect_ev(1, 0, 0, 0, 0);
      expect_ev(2, 7, 28, 0, 33);
      westClosed = 1'b0;
      reqWest = 1'b1;
      wait_sig("s3_busy", 2, 10, n);
      reqWest = 1'b0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         cnt += int'(openWest);
      end
      chk("s3_no_pulse_gate_open", cnt, 0);
      chk("s3_busy_hold", int'(busy), 1);
      @(posedge clk); #1 westClosed = 1'b1;
      wait_sig("s3_openW", 0, 10, n);
      pass_gondola();
      tick(5);
      pass_gondola();
      tick(3);
      eastClosed = 1'b0;
      @(posedge clk); #1 lvl_a = int'(level);
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         acc += int'(fillValve | drainValve);
      end
      lvl_b = int'(level);
      eastClosed = 1'b1;
      chk("s3_valves_paused", acc, 0);
      chk("s3_level_frozen", lvl_b, lvl_a);
      wait_sig("s3_openE", 1, 100, n);
      pass_gondola();
      wait_sig("s3_idle", 3, 10, n);
      chk("s3_final_level", int'(level), 7);

      // West request at level 7: drain in PREP; gondolaPassed in PREP ignored
      expect_ev(1, 0, 0, 28, 28);
      expect_ev(2, 7, 28, 0, 28);
      reqWest = 1'b1;
      wait_sig("s4_busy", 2, 10, n);
      reqWest = 1'b0;
      tick(5);
      pass_gondola();
      wait_sig("s4_openW", 0, 100, n);
      pass_gondola();
      wait_sig("s4_openE", 1, 100, n);
      pass_gondola();
      wait_sig("s4_idle", 3, 10, n);
      chk("s4_final_level", int'(level), 7);

      // Reset from idle at level 7, then asynchronous reset mid-fill at level 3
      @(negedge clk) reset = 1'b0;
      tick(2);
      chk("s5_rst_level", int'(level), 0);
      @(negedge clk) reset = 1'b1;
      expect_ev(1, 0, 0, 0, 0);
      expect_ev(2, 7, 28, 0, 28);
      reqWest = 1'b1;
      wait_sig("s5_busy", 2, 10, n);
      reqWest = 1'b0;
      wait_sig("s5_openW", 0, 20, n);
      pass_gondola();
      n = 0;
      while (!(level == 3'd3 && fillValve) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("s5_reach_level3_fill", int'(level == 3'd3 && fillValve), 1);
      #2 reset = 1'b0;
      sb.delete();
      #1;
      chk("s5_async_fill", int'(fillValve), 0);
      chk("s5_async_busy", int'(busy), 0);
      chk("s5_async_level", int'(level), 0);
      chk("s5_async_opens", int'(openWest | openEast), 0);
      tick(3);
      @(negedge clk) reset = 1'b1;
      tick(2);
      chk("s5_post_busy", int'(busy), 0);
      chk("s5_post_level", int'(level), 0);
      expect_ev(1, 0, 0, 0, 0);
      expect_ev(2, 7, 28, 0, 28);
      reqWest = 1'b1;
      wait_sig("s5b_busy", 2, 10, n);
      reqWest = 1'b0;
      wait_sig("s5b_openW", 0, 20, n);
      chk("s5b_prep_latency", n, 2);
      pass_gondola();
      wait_sig("s5b_openE", 1, 100, n);
      pass_gondola();
      wait_sig("s5b_idle", 3, 10, n);

      tick(2);
      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/lock_controller.md
LOCK_CONTROLLER -- requirements
Module: lock_controller

Interface
REQ-001 The module SHALL have parameter LEVEL_MAX, default 7, meaning the pound water level at the high (east) side; level 0 is the low (west) side.
REQ-002 The module SHALL have parameter STEP_CYCLES, default 4, meaning the clock cycles per one-unit level change while filling or draining.
REQ-003 clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous reset, active-low: reset=0 resets immediately, independent of clk.
REQ-005 reqWest  input  1  level-sensitive; a gondola is waiting at the west gate to go east.
REQ-006 reqEast  input  1  level-sensitive; a gondola is waiting at the east gate to go west.
REQ-007 gondolaPassed  input  1  one-cycle pulse; the gondola has cleared the gate currently open.
REQ-008 westClosed, eastClosed  input  1 each  gateClosed outputs of the two gate instances.
REQ-009 openWest, openEast  output  1 each  one-cycle open pulses, each driving one gate's openSignal.
REQ-010 fillValve, drainValve  output  1 each  valve drives that raise or lower the water level.
REQ-011 level  output  $clog2(LEVEL_MAX+1)  current water level.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL use states IDLE, PREP, OPEN_IN, WAIT_IN, MOVE, OPEN_OUT, WAIT_OUT, plus a direction register dir (0 = west-to-east, 1 = east-to-west).
REQ-014 IDLE: if reqWest and reqEast are both high, dir SHALL be 1 when level==LEVEL_MAX and 0 otherwise; otherwise dir is set from whichever request is high, and the next state is PREP; with no request, the FSM stays in IDLE.
REQ-015 PREP: the entry level SHALL be 0 for dir=0 and LEVEL_MAX for dir=1; at the entry level the FSM goes to OPEN_IN next cycle, otherwise it drains (dir=0) or fills (dir=1).
REQ-016 MOVE: the exit level SHALL be LEVEL_MAX for dir=0 and 0 for dir=1; the FSM fills or drains toward it and goes to OPEN_OUT once level equals it.
REQ-017 Level change: while a valve is active, a step counter SHALL count 0..STEP_CYCLES-1, and level changes by exactly 1 in the cycle the counter wraps; the counter clears on entry to PREP/MOVE.
REQ-018 Level SHALL saturate at 0 and LEVEL_MAX; no wrap-around under any input.
REQ-019 Interlock: fillValve and drainValve SHALL never both be 1, and SHALL both be 0 in any cycle where westClosed or eastClosed is 0; the step counter holds (pauses) during such cycles.
REQ-020 OPEN_IN: the module SHALL pulse the entry-side open output (openWest for dir=0, openEast for dir=1) for exactly one cycle, only in a cycle where both closed inputs are 1, then go to WAIT_IN; otherwise it waits in OPEN_IN with no pulse.
REQ-021 WAIT_IN: the FSM SHALL go to MOVE on gondolaPassed, and otherwise stay in WAIT_IN indefinitely.
REQ-022 OPEN_OUT and WAIT_OUT SHALL behave as OPEN_IN and WAIT_IN using the exit-side gate; WAIT_OUT returns to IDLE on gondolaPassed.
REQ-023 gondolaPassed SHALL be ignored in all states other than WAIT_IN and WAIT_OUT; requests SHALL be sampled only in IDLE.
REQ-024 openWest and openEast SHALL never be high in the same cycle, and neither SHALL be high while any valve is high.
REQ-025 All outputs SHALL be registered or decoded from registered state only (no combinational path from inputs to outputs).

Reset
REQ-026 While reset=0: state=IDLE, dir=0, level=0, step counter=0, and all open/valve outputs and busy = 0.
REQ-027 Reset asserted mid-operation (any state, including a valve active) SHALL force REQ-026 values immediately; operation restarts from IDLE with level 0 after reset=1.

Verification
REQ-028 Reset, then reqWest=1 at level 0, both closed=1: PREP 1 cycle -> openWest pulse 1 cycle -> on gondolaPassed, fillValve high 28 cycles, level 0->7 -> openEast pulse -> on gondolaPassed, IDLE.
REQ-029 At level 7, both requests high -> dir=1, openEast pulse with no prior valve activity; full trip drains to 0 and ends with an openWest pulse.
REQ-030 During MOVE, hold eastClosed=0 for 5 cycles -> valves 0 and level frozen for those 5 cycles, then resumes; total fill time = 28+5 cycles.
REQ-031 During OPEN_IN with westClosed=0 -> no openWest pulse until westClosed returns to 1; a gondolaPassed pulse in PREP or MOVE has no effect.
REQ-032 Assert reset=0 asynchronously at level 3 mid-fill -> outputs drop without waiting for clk; level=0 and IDLE after release.
